// File: rtl/auth_initiator_pkg.sv
// Shared constants for the authentication initiator: message codes, protocol
// version, error codes, FSM states and header field positions.
package auth_initiator_pkg;

  localparam logic [7:0] PROTO_VER        = 8'h01;

  localparam logic [7:0] REQ_GET_DIGESTS  = 8'h81;
  localparam logic [7:0] REQ_GET_CERT     = 8'h82;
  localparam logic [7:0] REQ_CHALLENGE    = 8'h83;

  localparam logic [7:0] RSP_DIGESTS      = 8'h01;
  localparam logic [7:0] RSP_CERT         = 8'h02;
  localparam logic [7:0] RSP_CHAL_AUTH    = 8'h03;
  localparam logic [7:0] RSP_ERROR        = 8'h7F;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_TIMEOUT = 3'd1,
    ERR_PROTO   = 3'd2,
    ERR_TYPE    = 3'd3,
    ERR_RESP    = 3'd4,
    ERR_SLOT    = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_DIG,
    ST_WAIT_DIG,
    ST_SEND_CERT,
    ST_WAIT_CERT,
    ST_SEND_CHAL,
    ST_WAIT_CHAL,
    ST_FINISH
  } state_e;

  // Header field index counted from the least significant header field.
  localparam int FLD_VER  = 3;
  localparam int FLD_TYPE = 2;
  localparam int FLD_P1   = 1;
  localparam int FLD_P2   = 0;

  function automatic int hdr_lsb(input int msg_len, input int hdr_w, input int fld);
    return msg_len - 4 * hdr_w + fld * hdr_w;
  endfunction

endpackage

// File: rtl/auth_msg_pack.sv
// Combinational request builder: header {version, type, param1, param2} in the
// top bits, nonce in the low 32 payload bits, everything else zero.
module auth_msg_pack #(
  parameter int MSG_LEN = 256,
  parameter int HDR_W   = 8
) (
  input  logic [HDR_W-1:0]   msg_type,
  input  logic [HDR_W-1:0]   param1,
  input  logic [HDR_W-1:0]   param2,
  input  logic [31:0]        nonce,
  output logic [MSG_LEN-1:0] msg
);
  import auth_initiator_pkg::*;

  localparam int VER_LSB  = hdr_lsb(MSG_LEN, HDR_W, FLD_VER);
  localparam int TYPE_LSB = hdr_lsb(MSG_LEN, HDR_W, FLD_TYPE);
  localparam int P1_LSB   = hdr_lsb(MSG_LEN, HDR_W, FLD_P1);
  localparam int P2_LSB   = hdr_lsb(MSG_LEN, HDR_W, FLD_P2);

  always_comb begin
    msg                     = '0;
    msg[VER_LSB  +: HDR_W]  = HDR_W'(PROTO_VER);
    msg[TYPE_LSB +: HDR_W]  = msg_type;
    msg[P1_LSB   +: HDR_W]  = param1;
    msg[P2_LSB   +: HDR_W]  = param2;
    msg[31:0]               = nonce;
  end

endmodule

// File: rtl/auth_initiator.sv
// Authentication initiator FSM: GET_DIGESTS, CERT_CHUNKS x GET_CERTIFICATE,
// CHALLENGE, with reply checking. Define AUTH_INIT_RETRY_EN to resend on timeout.
module auth_initiator #(
  parameter int MSG_LEN        = 256,
  parameter int HDR_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRIES    = 2,
  parameter int CERT_CHUNKS    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         slot,
  input  logic [31:0]        nonce_in,
  input  logic               resp_valid_in,
  input  logic [MSG_LEN-1:0] auth_msg_init_in,
  output logic               req_out,
  output logic [MSG_LEN-1:0] auth_msg_init_out,
  output logic               busy,
  output logic               done,
  output logic               auth_ok,
  output logic [2:0]         err_code
);
  import auth_initiator_pkg::*;

  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CHUNK_W  = (CERT_CHUNKS > 1) ? $clog2(CERT_CHUNKS) : 1;
  localparam int VER_LSB  = hdr_lsb(MSG_LEN, HDR_W, FLD_VER);
  localparam int TYPE_LSB = hdr_lsb(MSG_LEN, HDR_W, FLD_TYPE);
  localparam int P1_LSB   = hdr_lsb(MSG_LEN, HDR_W, FLD_P1);
  localparam int P2_LSB   = hdr_lsb(MSG_LEN, HDR_W, FLD_P2);

  state_e               state_q, state_d;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic [CHUNK_W-1:0]   chunk_q;
  logic [2:0]           slot_q;
  logic [31:0]          nonce_q;
  err_e                 err_q;

  logic                 start_acc, wait_st, tmo_hit, last_chunk;
  logic                 fin, fin_ok, chunk_adv;
  err_e                 fin_err, rsp_err;
  state_e               resend_st;
  logic [HDR_W-1:0]     exp_type;
  logic [HDR_W-1:0]     pk_type, pk_p1, pk_p2;
  logic [31:0]          pk_nonce;
  logic [MSG_LEN-1:0]   pk_msg;

  logic [HDR_W-1:0]     rsp_ver, rsp_type, rsp_p2;
  logic                 unused_rsp_bits;

  assign rsp_ver         = auth_msg_init_in[VER_LSB  +: HDR_W];
  assign rsp_type        = auth_msg_init_in[TYPE_LSB +: HDR_W];
  assign rsp_p2          = auth_msg_init_in[P2_LSB   +: HDR_W];
  assign unused_rsp_bits = ^{auth_msg_init_in[P1_LSB +: HDR_W],
                             auth_msg_init_in[MSG_LEN-4*HDR_W-1:0]};

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign wait_st    = state_q inside {ST_WAIT_DIG, ST_WAIT_CERT, ST_WAIT_CHAL};
  assign tmo_hit    = wait_st && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign last_chunk = (chunk_q == CHUNK_W'(CERT_CHUNKS - 1));

`ifdef AUTH_INIT_RETRY_EN
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RTY_W-1:0] retry_q;
  logic             retry_inc;
`else
  logic [31:0]      unused_max_retries;
  assign unused_max_retries = MAX_RETRIES;
`endif

  // Per-wait-state context: expected reply and the request to repeat.
  always_comb begin
    exp_type  = '0;
    resend_st = ST_IDLE;
    case (state_q)
      ST_WAIT_DIG:  begin exp_type = HDR_W'(RSP_DIGESTS);   resend_st = ST_SEND_DIG;  end
      ST_WAIT_CERT: begin exp_type = HDR_W'(RSP_CERT);      resend_st = ST_SEND_CERT; end
      ST_WAIT_CHAL: begin exp_type = HDR_W'(RSP_CHAL_AUTH); resend_st = ST_SEND_CHAL; end
      default: ;
    endcase
  end

  // Reply checks in priority order: version, ERROR, type, slot presence.
  always_comb begin
    rsp_err = ERR_NONE;
    if (rsp_ver != HDR_W'(PROTO_VER))              rsp_err = ERR_PROTO;
    else if (rsp_type == HDR_W'(RSP_ERROR))        rsp_err = ERR_RESP;
    else if (rsp_type != exp_type)                 rsp_err = ERR_TYPE;
    else if (state_q == ST_WAIT_DIG && !rsp_p2[slot_q]) rsp_err = ERR_SLOT;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    fin       = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = ERR_NONE;
    chunk_adv = 1'b0;
    pk_type   = '0;
    pk_p1     = '0;
    pk_p2     = '0;
    pk_nonce  = '0;
`ifdef AUTH_INIT_RETRY_EN
    retry_inc = 1'b0;
`endif
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_SEND_DIG;
      ST_SEND_DIG:  begin
        pk_type = HDR_W'(REQ_GET_DIGESTS);
        state_d = ST_WAIT_DIG;
      end
      ST_SEND_CERT: begin
        pk_type = HDR_W'(REQ_GET_CERT);
        pk_p1   = HDR_W'(slot_q);
        pk_p2   = HDR_W'(chunk_q);
        state_d = ST_WAIT_CERT;
      end
      ST_SEND_CHAL: begin
        pk_type  = HDR_W'(REQ_CHALLENGE);
        pk_p1    = HDR_W'(slot_q);
        pk_nonce = nonce_q;
        state_d  = ST_WAIT_CHAL;
      end
      ST_WAIT_DIG, ST_WAIT_CERT, ST_WAIT_CHAL: begin
        if (resp_valid_in) begin
          if (rsp_err != ERR_NONE) begin
            fin     = 1'b1;
            fin_err = rsp_err;
          end else if (state_q == ST_WAIT_DIG) begin
            state_d = ST_SEND_CERT;
          end else if (state_q == ST_WAIT_CERT) begin
            chunk_adv = 1'b1;
            state_d   = last_chunk ? ST_SEND_CHAL : ST_SEND_CERT;
          end else begin
            fin    = 1'b1;
            fin_ok = 1'b1;
          end
        end else if (tmo_hit) begin
`ifdef AUTH_INIT_RETRY_EN
          if (retry_q < RTY_W'(MAX_RETRIES)) begin
            state_d   = resend_st;
            retry_inc = 1'b1;
          end else begin
            fin     = 1'b1;
            fin_err = ERR_TIMEOUT;
          end
`else
          fin     = 1'b1;
          fin_err = ERR_TIMEOUT;
`endif
        end
      end
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (fin) state_d = ST_FINISH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      chunk_q   <= '0;
      slot_q    <= '0;
      nonce_q   <= '0;
      auth_ok   <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= wait_st ? tmo_cnt_q + 1'b1 : '0;
      if (start_acc) begin
        slot_q  <= slot;
        nonce_q <= nonce_in;
        chunk_q <= '0;
        auth_ok <= 1'b0;
        err_q   <= ERR_NONE;
      end else if (chunk_adv) begin
        chunk_q <= chunk_q + 1'b1;
      end
      if (fin) begin
        auth_ok <= fin_ok;
        err_q   <= fin_err;
      end
    end
  end

`ifdef AUTH_INIT_RETRY_EN
  always_ff @(posedge clk) begin
    if (!reset)                                      retry_q <= '0;
    else if (start_acc || (wait_st && resp_valid_in)) retry_q <= '0;
    else if (retry_inc)                              retry_q <= retry_q + 1'b1;
  end
`endif

  auth_msg_pack #(
    .MSG_LEN (MSG_LEN),
    .HDR_W   (HDR_W)
  ) u_pack (
    .msg_type (pk_type),
    .param1   (pk_p1),
    .param2   (pk_p2),
    .nonce    (pk_nonce),
    .msg      (pk_msg)
  );

  assign req_out           = state_q inside {ST_SEND_DIG, ST_SEND_CERT, ST_SEND_CHAL};
  assign busy              = !(state_q inside {ST_IDLE, ST_FINISH});
  assign done              = (state_q == ST_FINISH);
  assign auth_msg_init_out = req_out ? pk_msg : '0;
  assign err_code          = err_q;

endmodule

// File: tb/tb_auth_initiator.sv
// Self-checking bench for auth_initiator: directed scenario table, hand-written
// reset sequences and randomized scenarios checked against a rule-level model.
module tb_auth_initiator;

  localparam int MSG_LEN = 256;
  localparam int HDR_W   = 8;
  localparam int TMO     = 1000;
  localparam int MAXR    = 2;
  localparam int CH      = 4;
`ifdef AUTH_INIT_RETRY_EN
  localparam int RETRY_EXTRA = MAXR;
`else
  localparam int RETRY_EXTRA = 0;
`endif
  localparam int RUN_BUDGET = (CH + 2) * (TMO + 8) * (MAXR + 1) + 50;

  typedef enum int {F_NONE, F_VER, F_ERR, F_TYPE, F_TMO} fault_e;

  typedef struct {
    logic [2:0]  slot;
    logic [31:0] nonce;
    logic [7:0]  dig_p2;
    fault_e      fault;
    int          fstep;     // request index whose reply is faulty, -1 none
    int          delay;     // reply delay in cycles, 0 = random 1..4
    bit          noise;     // stray start / resp_valid_in while busy
    bit          exp_ok;
    logic [2:0]  exp_err;
    int          exp_nreq;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [2:0]         slot;
  logic [31:0]        nonce_in;
  logic               resp_valid_in;
  logic [MSG_LEN-1:0] auth_msg_init_in;
  logic               req_out;
  logic [MSG_LEN-1:0] auth_msg_init_out;
  logic               busy, done, auth_ok;
  logic [2:0]         err_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  auth_initiator #(
    .MSG_LEN        (MSG_LEN),
    .HDR_W          (HDR_W),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (MAXR),
    .CERT_CHUNKS    (CH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .slot              (slot),
    .nonce_in          (nonce_in),
    .resp_valid_in     (resp_valid_in),
    .auth_msg_init_in  (auth_msg_init_in),
    .req_out           (req_out),
    .auth_msg_init_out (auth_msg_init_out),
    .busy              (busy),
    .done              (done),
    .auth_ok           (auth_ok),
    .err_code          (err_code)
  );

  task automatic check(input string name, input logic [MSG_LEN-1:0] act,
                       input logic [MSG_LEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected request for the i-th distinct step of a sequence.
  function automatic logic [MSG_LEN-1:0] exp_req(input int step, input logic [2:0] sl,
                                                 input logic [31:0] n);
    logic [MSG_LEN-1:0] m;
    m = '0;
    if (step == 0)
      m[MSG_LEN-1 -: 32] = {8'h01, 8'h81, 8'h00, 8'h00};
    else if (step <= CH)
      m[MSG_LEN-1 -: 32] = {8'h01, 8'h82, 5'b0, sl, 8'(step - 1)};
    else begin
      m[MSG_LEN-1 -: 32] = {8'h01, 8'h83, 5'b0, sl, 8'h00};
      m[31:0] = n;
    end
    return m;
  endfunction

  function automatic logic [MSG_LEN-1:0] mk_rsp(input logic [7:0] ver, input logic [7:0] typ,
                                                input logic [7:0] p1, input logic [7:0] p2);
    logic [MSG_LEN-1:0] m;
    for (int i = 0; i < MSG_LEN / 32; i++) m[i*32 +: 32] = $urandom;
    m[MSG_LEN-1 -: 32] = {ver, typ, p1, p2};
    return m;
  endfunction

  // Outcome from the protocol rules: walk the request list, stop at the first fault.
  task automatic model(input vec_t v, output bit ok, output logic [2:0] err, output int nreq);
    bit stop;
    ok = 1'b0; err = 3'd0; nreq = 0; stop = 1'b0;
    for (int st = 0; st <= CH + 1 && !stop; st++) begin
      nreq = st + 1;
      if (v.fault != F_NONE && st == v.fstep) begin
        stop = 1'b1;
        case (v.fault)
          F_VER:   err = 3'd2;
          F_ERR:   err = 3'd4;
          F_TYPE:  err = 3'd3;
          default: begin err = 3'd1; nreq = nreq + RETRY_EXTRA; end
        endcase
      end else if (st == 0 && !v.dig_p2[v.slot]) begin
        stop = 1'b1;
        err  = 3'd5;
      end
    end
    if (!stop) ok = 1'b1;
  endtask

  // Acts as the responder for one full authentication and checks the outcome.
  task automatic run_vec(input vec_t v, input string tag);
    int cur_step, nreq, last_req_cyc, last_rsp_cyc, countdown, done_cyc, exp_req_cyc, cyc;
    bit pending, got_done, busy_bad;
    logic got_ok;
    logic [2:0] got_err;
    fault_e f;
    logic [7:0] et, ver, typ, p2;
    cur_step = 0; nreq = 0; last_req_cyc = 0; last_rsp_cyc = 0; countdown = 0;
    done_cyc = 0; exp_req_cyc = 1; pending = 1'b0; got_done = 1'b0; busy_bad = 1'b0;
    got_ok = 1'b0; got_err = 3'd0;
    @(negedge clk);
    resp_valid_in = 1'b0; slot = v.slot; nonce_in = v.nonce; start = 1'b1;
    cyc = 0;
    while (!got_done && cyc < RUN_BUDGET) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; resp_valid_in = 1'b0;
      if (done === 1'b1) begin
        got_done = 1'b1; done_cyc = cyc; got_ok = auth_ok; got_err = err_code;
        if (busy !== 1'b0) busy_bad = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (req_out === 1'b1) begin
          nreq++;
          check({tag, "_req_msg"}, auth_msg_init_out, exp_req(cur_step, v.slot, v.nonce));
          if (exp_req_cyc > 0) begin
            check({tag, "_req_latency"}, cyc, exp_req_cyc);
            exp_req_cyc = 0;
          end
          last_req_cyc = cyc;
          pending   = !(v.fault == F_TMO && cur_step == v.fstep);
          countdown = (v.delay > 0) ? v.delay : int'($urandom_range(1, 4));
          if (v.noise) begin
            resp_valid_in    = 1'b1;
            auth_msg_init_in = mk_rsp(8'h01, 8'h7F, 8'h00, 8'h00);
          end
        end else if (pending) begin
          countdown--;
          if (countdown == 0) begin
            pending = 1'b0; last_rsp_cyc = cyc;
            f   = (cur_step == v.fstep) ? v.fault : F_NONE;
            et  = (cur_step == 0) ? 8'h01 : (cur_step <= CH) ? 8'h02 : 8'h03;
            ver = 8'h01; typ = et;
            p2  = (cur_step == 0) ? v.dig_p2 : 8'($urandom);
            case (f)
              F_VER:  begin
                ver = 8'($urandom_range(2, 255));
                if ($urandom_range(0, 1) == 1) typ = 8'h7F;
              end
              F_ERR:  typ = 8'h7F;
              F_TYPE: typ = (et == 8'h03) ? 8'h01 : et + 8'h01;
              default: ;
            endcase
            resp_valid_in    = 1'b1;
            auth_msg_init_in = mk_rsp(ver, typ, 8'($urandom), p2);
            if (f == F_NONE && !(cur_step == 0 && !v.dig_p2[v.slot]) && cur_step <= CH) begin
              cur_step++;
              exp_req_cyc = cyc + 1;
            end
          end
        end
        if (v.noise) start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0; resp_valid_in = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);
    if (got_done) begin
      check({tag, "_auth_ok"}, got_ok, v.exp_ok);
      check({tag, "_err_code"}, got_err, v.exp_err);
      check({tag, "_req_count"}, nreq, v.exp_nreq);
      check({tag, "_busy_shape"}, busy_bad, 0);
      if (v.exp_err == 3'd1) check({tag, "_tmo_latency"}, done_cyc - last_req_cyc, TMO + 1);
      else                   check({tag, "_done_latency"}, done_cyc - last_rsp_cyc, 1);
    end
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    reset = 1'b0; start = 1'b0; slot = '0; nonce_in = '0;
    resp_valid_in = 1'b0; auth_msg_init_in = '0;

    //                slot  nonce          dp2    fault   fst  dly  noise ok  err   nreq
    vecs[0] = '{3'd2, 32'hA5A5_0001, 8'h04, F_NONE, -1,  0,   1'b0, 1'b1, 3'd0, 6};
    vecs[1] = '{3'd2, 32'h1234_5678, 8'h04, F_VER,   0,  0,   1'b0, 1'b0, 3'd2, 1};
    vecs[2] = '{3'd2, 32'h0BAD_F00D, 8'hFF, F_ERR,   3,  0,   1'b0, 1'b0, 3'd4, 4};
    vecs[3] = '{3'd1, 32'h0000_0001, 8'h01, F_NONE, -1,  0,   1'b0, 1'b0, 3'd5, 1};
    vecs[4] = '{3'd0, 32'hCAFE_0005, 8'h01, F_TMO,   5,  0,   1'b0, 1'b0, 3'd1, 6 + RETRY_EXTRA};
    vecs[5] = '{3'd4, 32'h5555_AAAA, 8'h10, F_TYPE,  1,  0,   1'b0, 1'b0, 3'd3, 2};
    vecs[6] = '{3'd7, 32'hFFFF_FFFF, 8'h80, F_NONE, -1,  0,   1'b1, 1'b1, 3'd0, 6};
    vecs[7] = '{3'd3, 32'h0000_BEEF, 8'h08, F_NONE, -1,  TMO, 1'b0, 1'b1, 3'd0, 6};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req_out", req_out, 0);
    check("rst_done", done, 0);
    check("rst_auth_ok", auth_ok, 0);
    check("rst_err_code", err_code, 0);
    check("rst_msg_out", auth_msg_init_out, '0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      // Verdict must hold in idle, and replies outside a wait are ignored.
      @(negedge clk);
      resp_valid_in = 1'b1; auth_msg_init_in = mk_rsp(8'h01, 8'h7F, 8'h00, 8'h00);
      @(negedge clk);
      resp_valid_in = 1'b0;
      check($sformatf("vec%0d_idle_busy", i), {busy, req_out, done}, 3'b000);
      check($sformatf("vec%0d_hold_ok", i), auth_ok, vecs[i].exp_ok);
      check($sformatf("vec%0d_hold_err", i), err_code, vecs[i].exp_err);
    end

    // Reset while waiting for a certificate reply.
    @(negedge clk); slot = 3'd0; nonce_in = 32'h1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); resp_valid_in = 1'b1; auth_msg_init_in = mk_rsp(8'h01, 8'h01, 8'h00, 8'h01);
    @(negedge clk); resp_valid_in = 1'b0;
    check("mid_cert_req", req_out, 1);
    @(negedge clk);
    check("mid_wait_cert", {busy, req_out}, 2'b10);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    check("mid_rst_outputs", {busy, req_out, done, auth_ok, err_code}, 7'd0);
    @(negedge clk); start = 1'b1; slot = 3'd5; nonce_in = 32'h77;
    @(negedge clk); start = 1'b0;
    check("post_rst_req", req_out, 1);
    check("post_rst_msg", auth_msg_init_out, exp_req(0, 3'd5, 32'h77));

    // Reset and start at the same edge: reset wins.
    @(negedge clk); reset = 1'b0; start = 1'b1;
    @(negedge clk); reset = 1'b1; start = 1'b0;
    check("rst_vs_start", {busy, req_out, done}, 3'b000);
    @(negedge clk);
    check("rst_vs_start_idle", {busy, req_out}, 2'b00);

    for (int i = 0; i < 20; i++) begin
      rv.slot   = 3'($urandom);
      rv.nonce  = $urandom;
      rv.dig_p2 = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rv.dig_p2[rv.slot] = 1'b1;
      case ($urandom_range(0, 9))
        5:       rv.fault = F_VER;
        6:       rv.fault = F_ERR;
        7, 8:    rv.fault = F_TYPE;
        9:       rv.fault = F_TMO;
        default: rv.fault = F_NONE;
      endcase
      rv.fstep = (rv.fault == F_NONE) ? -1 : int'($urandom_range(0, CH + 1));
      rv.delay = ($urandom_range(0, 9) == 0) ? TMO : 0;
      rv.noise = 1'($urandom);
      model(rv, rv.exp_ok, rv.exp_err, rv.exp_nreq);
      run_vec(rv, $sformatf("rnd%0d", i));
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/auth_initiator.md
Name: auth_initiator

Overview:
- Authentication initiator for the USB Type-C authentication driver. It is the requesting end of the protocol that the responder block serves.
- On `start` it issues three request types in order: GET_DIGESTS, then GET_CERTIFICATE for every certificate chunk, then CHALLENGE.
- Each reply is checked for protocol version, expected message type, ERROR responses and timeout. A single pass/fail verdict with an error code is reported.
- It sits between host control logic and the message transport that feeds the responder.

Parameters:
- MSG_LEN, 256, total message width in bits (header plus payload).
- HDR_W, 8, width of each header field (ProtocolVersion, MessageType, Param1, Param2).
- TIMEOUT_CYCLES, 1000, cycles to wait for a response after a request pulse.
- MAX_RETRIES, 2, resends of the same request after a timeout (used only with the optional feature).
- CERT_CHUNKS, 4, number of GET_CERTIFICATE requests per authentication (at least 1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- slot  in  3  certificate slot; sampled at start.
- nonce_in  in  32  challenge nonce; sampled at start.
- resp_valid_in  in  1  one-cycle pulse: auth_msg_init_in is valid.
- auth_msg_init_in  in  MSG_LEN  response message, header in the top 4*HDR_W bits.
- req_out  out  1  one-cycle pulse: auth_msg_init_out is valid.
- auth_msg_init_out  out  MSG_LEN  request message.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence ends.
- auth_ok  out  1  verdict; valid from done until the next accepted start.
- err_code  out  3  failure reason; held with auth_ok.

Behaviour:
- Reset (reset==0 at a clk edge): state goes to IDLE and all outputs are 0. Reset wins over every other event, including mid-sequence.
- Header layout: {ProtocolVersion, MessageType, Param1, Param2}, MSB first. ProtocolVersion sent is always 8'h01.
- Request codes:
  - GET_DIGESTS: 8'h81, Param1=0, Param2=0, payload 0.
  - GET_CERTIFICATE: 8'h82, Param1=slot, Param2=chunk index, payload 0.
  - CHALLENGE: 8'h83, Param1=slot, Param2=0, payload low 32 bits = nonce, rest 0.
- Expected response codes: DIGESTS 8'h01, CERTIFICATE 8'h02, CHALLENGE_AUTH 8'h03, ERROR 8'h7F.
- States: IDLE, SEND_DIG, WAIT_DIG, SEND_CERT, WAIT_CERT, SEND_CHAL, WAIT_CHAL, FINISH.
- Each SEND_* state lasts exactly one cycle: req_out=1 and the message is driven. The next cycle enters the matching WAIT_*, the timeout counter clears and it increments every WAIT cycle.
- Latency: start sampled in IDLE at edge N gives req_out=1 during cycle N+1. A response accepted at edge M gives the next req_out during cycle M+1.
- Response checks in WAIT_*, evaluated in this order:
  - ProtocolVersion != 1 → FINISH, err=2.
  - Type 8'h7F → FINISH, err=4.
  - Type differs from expected → FINISH, err=3.
  - WAIT_DIG only: Param2 bit[slot]==0 (slot not populated) → FINISH, err=5.
  - Otherwise advance.
- WAIT_CERT: chunk counter increments per accepted CERTIFICATE. Return to SEND_CERT until CERT_CHUNKS responses have been accepted, then go to SEND_CHAL.
- Accepted CHALLENGE_AUTH → FINISH with auth_ok=1, err=0.
- FINISH: done=1 for one cycle, busy=0, auth_ok/err_code latched, return to IDLE.
- Timeout: the counter reaching TIMEOUT_CYCLES without a response → FINISH, err=1.
- Simultaneous response and timeout expiry in the same cycle: the response wins.
- resp_valid_in outside WAIT_* is ignored. start outside IDLE is ignored.
- err_code map: 0 none, 1 timeout, 2 unsupported protocol, 3 unexpected type, 4 responder ERROR, 5 slot empty. Codes 6 and 7 are reserved.

Optional Feature:
- Macro: AUTH_INIT_RETRY_EN.
- When defined: a timeout returns to the same SEND_* state, resending an identical message (same chunk index), and the retry counter increments. err=1 is reported only after MAX_RETRIES resends have also timed out. The retry counter clears on every accepted response and on start.
- When undefined: the first timeout goes straight to FINISH with err=1, and no retry counter is instantiated.

Decomposition:
- Shared package/header (extends the existing parameters include):
  - request/response MessageType codes;
  - protocol version constant;
  - err_code enumeration;
  - state encodings;
  - header field offsets.
- One sub-module, auth_msg_pack: combinational header/payload builder from {type, param1, param2, nonce}. The FSM, counters and checks stay in auth_initiator.

Test Plan:
- Happy path: slot=2, nonce=32'hA5A5_0001; responder answers DIGESTS with Param2=8'h04, then 4 CERTIFICATEs, then CHALLENGE_AUTH → exactly 6 req_out pulses with Param2 chunk indices 0,1,2,3 on certificates; done pulse, auth_ok=1, err_code=0.
- Version error: DIGESTS response with ProtocolVersion=8'h02 → done the cycle after, auth_ok=0, err_code=2, no GET_CERTIFICATE sent.
- Responder ERROR: third CERTIFICATE reply of type 8'h7F → done, err_code=4. Slot empty: slot=1 with DIGESTS Param2=8'h01 → err_code=5.
- Timeout: no response to CHALLENGE → done exactly TIMEOUT_CYCLES+1 cycles after its req_out, err_code=1. With AUTH_INIT_RETRY_EN, MAX_RETRIES=2: 3 identical CHALLENGE pulses, then err_code=1.
- Boundary: response arriving in the same cycle as timeout expiry is accepted. start and stray resp_valid_in while busy are ignored.
- Reset mid-sequence: reset low during WAIT_CERT → next cycle busy=0, req_out=0, done=0, auth_ok=0, err_code=0. A new start gives a GET_DIGESTS request.
